aont_block_feeder: RTL

Upstream stage of the AONT core. Accepts one 512-bit message plus a 64-bit key over a valid/ready handshake. Slices the message into 8 data blocks of 16 four-bit Latin-square symbols each. Streams those blocks, followed by one key/check block, to the AONT core: 9 blocks per message, matching the core's noofblocks.

---
 rtl/aont_block_feeder_if.sv | 28 ++
 rtl/aont_block_feeder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/aont_block_feeder_if.sv
// Message-in / block-out handshake bundle for the AONT block feeder.
// master = feeder side, slave = the surrounding environment (message source + AONT core).
interface aont_block_feeder_if #(
  parameter int unsigned messgalen = 512,
  parameter int unsigned lslen     = 16,
  parameter int unsigned lslenlog  = 4
);
  logic [messgalen-1:0]      messageIn;
  logic [lslen*lslenlog-1:0] key_in;
  logic                      msg_valid;
  logic                      msg_ready;
  logic                      blk_valid;
  logic                      blk_ready;
  logic [lslen*lslenlog-1:0] blk_data;
  logic [3:0]                blk_idx;
  logic                      blk_last;
  logic                      busy;

  modport master (
    input  messageIn, key_in, msg_valid, blk_ready,
    output msg_ready, blk_valid, blk_data, blk_idx, blk_last, busy
  );

  modport slave (
    output messageIn, key_in, msg_valid, blk_ready,
    input  msg_ready, blk_valid, blk_data, blk_idx, blk_last, busy
  );
endinterface

// File: rtl/aont_block_feeder.sv
// Captures one message + key, then streams 8 data blocks (LSB block first) and one
// key block (key XOR all data blocks) to the AONT core over valid/ready.
module aont_block_feeder #(
  parameter int unsigned messgalen  = 512,
  parameter int unsigned noofblocks = 9,
  parameter int unsigned lslen      = 16,
  parameter int unsigned lslenlog   = 4
) (
  input logic                 clk,
  input logic                 rstn,
  aont_block_feeder_if.master bus
);

  localparam int unsigned BW    = lslen * lslenlog;
  localparam int unsigned NDATA = noofblocks - 1;
  localparam int unsigned IDXW  = (NDATA > 1) ? $clog2(NDATA) : 1;
  localparam logic [IDXW-1:0] LAST_DATA = IDXW'(NDATA - 1);
  localparam logic [3:0]      KEY_IDX   = 4'(NDATA);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    KEY  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [messgalen-1:0] msg_q, msg_d;
  logic [BW-1:0]        acc_q, acc_d;
  logic                 msg_ready_q, msg_ready_d;
  logic                 blk_valid_q, blk_valid_d;
  logic [BW-1:0]        blk_data_q, blk_data_d;
  logic [3:0]           blk_idx_q, blk_idx_d;
  logic                 blk_last_q, blk_last_d;
  logic                 busy_q, busy_d;

  logic            blk_hs;
  logic [IDXW-1:0] idx_nxt;
  logic [BW-1:0]   acc_nxt;

  assign blk_hs  = blk_valid_q && bus.blk_ready;
  assign idx_nxt = idx_q + 1'b1;
  assign acc_nxt = acc_q ^ blk_data_q;

  // Every output is precomputed for the next cycle, so blk_ready only steers
  // flop enables and never reaches blk_data/blk_idx combinationally.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    msg_d       = msg_q;
    acc_d       = acc_q;
    msg_ready_d = msg_ready_q;
    blk_valid_d = blk_valid_q;
    blk_data_d  = blk_data_q;
    blk_idx_d   = blk_idx_q;
    blk_last_d  = blk_last_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        msg_ready_d = 1'b1;
        blk_valid_d = 1'b0;
        blk_data_d  = '0;
        blk_idx_d   = '0;
        blk_last_d  = 1'b0;
        busy_d      = 1'b0;
        if (bus.msg_valid && msg_ready_q) begin
          state_d     = SEND;
          msg_d       = bus.messageIn;
          acc_d       = bus.key_in;
          idx_d       = '0;
          msg_ready_d = 1'b0;
          blk_valid_d = 1'b1;
          blk_data_d  = bus.messageIn[BW-1:0];
          busy_d      = 1'b1;
        end
      end

      SEND: begin
        if (blk_hs) begin
          acc_d = acc_nxt;
          if (idx_q == LAST_DATA) begin
            state_d    = KEY;
            blk_data_d = acc_nxt;
            blk_idx_d  = KEY_IDX;
            blk_last_d = 1'b1;
          end else begin
            idx_d      = idx_nxt;
            blk_data_d = msg_q[idx_nxt*BW +: BW];
            blk_idx_d  = 4'(idx_nxt);
          end
        end
      end

      KEY: begin
        if (blk_hs) begin
          state_d     = IDLE;
          msg_ready_d = 1'b1;
          blk_valid_d = 1'b0;
          blk_data_d  = '0;
          blk_idx_d   = '0;
          blk_last_d  = 1'b0;
          busy_d      = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        msg_ready_d = 1'b1;
        blk_valid_d = 1'b0;
        blk_data_d  = '0;
        blk_idx_d   = '0;
        blk_last_d  = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      msg_q       <= '0;
      acc_q       <= '0;
      msg_ready_q <= 1'b0;
      blk_valid_q <= 1'b0;
      blk_data_q  <= '0;
      blk_idx_q   <= '0;
      blk_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      msg_q       <= msg_d;
      acc_q       <= acc_d;
      msg_ready_q <= msg_ready_d;
      blk_valid_q <= blk_valid_d;
      blk_data_q  <= blk_data_d;
      blk_idx_q   <= blk_idx_d;
      blk_last_q  <= blk_last_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.msg_ready = msg_ready_q;
  assign bus.blk_valid = blk_valid_q;
  assign bus.blk_data  = blk_data_q;
  assign bus.blk_idx   = blk_idx_q;
  assign bus.blk_last  = blk_last_q;
  assign bus.busy      = busy_q;

endmodule
